weight_ram_loader: RTL

- Writer-side counterpart to the weight store of the linear neural network.
- Accepts a stream of 3-bit weights, one per handshake, and writes them sequentially into a 288-entry weight RAM.
- The RAM is organised as three neuron banks of 96 entries at bases 0, 96 and 192.
- Provides the registered three-bank read port the datapath already uses: weight1/2/3 come from addr, addr+96 and addr+192.

---
 rtl/nn_weight_pkg.sv | 23 ++
 rtl/weight_ram_loader_if.sv | 27 ++
 rtl/weight_ram_3r1w.sv | 53 +++++
 rtl/weight_ram_loader.sv | 102 ++++++++++
 4 files changed

// File: rtl/nn_weight_pkg.sv
// Shared constants for the linear network weight store: geometry, bank bases
// and the loader state encoding.
package nn_weight_pkg;

   localparam int WEIGHT_W    = 3;
   localparam int BANK_DEPTH  = 96;
   localparam int NUM_BANKS   = 3;
   localparam int TOTAL_DEPTH = BANK_DEPTH * NUM_BANKS;
   localparam int ADDR_W      = 10;
   localparam int RAM_AW      = 9;

   localparam logic [ADDR_W-1:0] BANK1_BASE = 10'd0;
   localparam logic [ADDR_W-1:0] BANK2_BASE = 10'd96;
   localparam logic [ADDR_W-1:0] BANK3_BASE = 10'd192;
   localparam logic [ADDR_W-1:0] BANK_LIMIT = 10'd96;
   localparam logic [ADDR_W-1:0] DEPTH_A    = 10'd288;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = 10'd287;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/weight_ram_loader_if.sv
// Load stream handshake, status and three-bank read port of the weight loader.
interface weight_ram_loader_if;
   import nn_weight_pkg::*;

   logic                load_start;
   logic                in_valid;
   logic                in_ready;
   logic [WEIGHT_W-1:0] in_data;
   logic                load_busy;
   logic                load_done;
   logic [ADDR_W-1:0]   wr_count;
   logic [ADDR_W-1:0]   rd_addr;
   logic [WEIGHT_W-1:0] weight1;
   logic [WEIGHT_W-1:0] weight2;
   logic [WEIGHT_W-1:0] weight3;

   modport master (
      output load_start, in_valid, in_data, rd_addr,
      input  in_ready, load_busy, load_done, wr_count, weight1, weight2, weight3
   );

   modport slave (
      input  load_start, in_valid, in_data, rd_addr,
      output in_ready, load_busy, load_done, wr_count, weight1, weight2, weight3
   );

endinterface

// File: rtl/weight_ram_3r1w.sv
// 288x3 weight storage: one synchronous write port, three registered bank reads
// returning pre-write data on a same-cycle collision.
module weight_ram_3r1w
   import nn_weight_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [WEIGHT_W-1:0] wdata,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [WEIGHT_W-1:0] rdata1,
   output logic [WEIGHT_W-1:0] rdata2,
   output logic [WEIGHT_W-1:0] rdata3
);

   logic [WEIGHT_W-1:0] mem [TOTAL_DEPTH];
   logic                in_range;
   logic [RAM_AW-1:0]   addr1;
   logic [RAM_AW-1:0]   addr2;
   logic [RAM_AW-1:0]   addr3;

   // Legal in-bank indices stay below 288, so the 9-bit sum matches the full-width one.
   assign in_range = (raddr < BANK_LIMIT);
   assign addr1    = raddr[RAM_AW-1:0] + BANK1_BASE[RAM_AW-1:0];
   assign addr2    = raddr[RAM_AW-1:0] + BANK2_BASE[RAM_AW-1:0];
   assign addr3    = raddr[RAM_AW-1:0] + BANK3_BASE[RAM_AW-1:0];

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we && (waddr < DEPTH_A)) begin
         mem[waddr[RAM_AW-1:0]] <= wdata;
      end
   end

   // Registered read of all three banks; out-of-range index reads as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata1 <= 3'd0;
         rdata2 <= 3'd0;
         rdata3 <= 3'd0;
      end else if (in_range) begin
         rdata1 <= mem[addr1];
         rdata2 <= mem[addr2];
         rdata3 <= mem[addr3];
      end else begin
         rdata1 <= 3'd0;
         rdata2 <= 3'd0;
         rdata3 <= 3'd0;
      end
   end

endmodule

// File: rtl/weight_ram_loader.sv
// Streams 288 weights into the three-bank weight RAM and exposes its registered
// read port; holds the load FSM, write pointer and handshake.
module weight_ram_loader
   import nn_weight_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   weight_ram_loader_if.slave bus
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] ptr_nxt;
   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] count_nxt;
   logic              done_nxt;
   logic              ready;
   logic              busy;
   logic              done;
   logic              we;

   // Next-state, pointer and write-enable decode.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = wr_ptr;
      count_nxt = count;
      done_nxt  = done;
      we        = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.load_start) begin
               state_nxt = ST_LOAD;
               ptr_nxt   = 10'd0;
               count_nxt = 10'd0;
               done_nxt  = 1'b0;
            end else begin
               state_nxt = state;
            end
         end
         ST_LOAD: begin
            // A restart outranks a coincident beat, which is dropped.
            if (bus.load_start) begin
               ptr_nxt   = 10'd0;
               count_nxt = 10'd0;
            end else if (bus.in_valid && ready) begin
               we        = 1'b1;
               count_nxt = count + 10'd1;
               if (wr_ptr == LAST_ADDR) begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end else begin
                  ptr_nxt = wr_ptr + 10'd1;
               end
            end else begin
               state_nxt = ST_LOAD;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
         end
      endcase
   end

   // FSM, counters and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         wr_ptr <= 10'd0;
         count  <= 10'd0;
         ready  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         wr_ptr <= ptr_nxt;
         count  <= count_nxt;
         ready  <= (state_nxt == ST_LOAD);
         busy   <= (state_nxt == ST_LOAD);
         done   <= done_nxt;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.load_busy = busy;
   assign bus.load_done = done;
   assign bus.wr_count  = count;

   weight_ram_3r1w u_ram (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (wr_ptr),
      .wdata  (bus.in_data),
      .raddr  (bus.rd_addr),
      .rdata1 (bus.weight1),
      .rdata2 (bus.weight2),
      .rdata3 (bus.weight3)
   );

endmodule
